// File: rtl/trit_pair_encoder.sv
// trit_pair_encoder
// Turns an unsigned binary value into a codeword of base-3 digits, one digit per
// clock, by repeated constant divide-by-3. Each aligned bit pair holds one digit
// coded 00/01/10, so 11 never appears on m_data. Words leave over a valid/ready
// stream; a new value is taken only once the previous word has been handed off.
module trit_pair_encoder #(
    parameter int DATA_W    = 6,
    parameter int NUM_TRITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [2*NUM_TRITS-1:0] m_data,
    output logic                   busy
);

    localparam int CNT_W = (NUM_TRITS > 1) ? $clog2(NUM_TRITS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_TRITS - 1);
    localparam logic [DATA_W-1:0] THREE    = DATA_W'(3);
    localparam longint            CODE_SPAN = longint'(3) ** NUM_TRITS;
    localparam longint            DATA_SPAN = longint'(1) << DATA_W;

    // Every binary input must fit in the available digits.
    if (DATA_SPAN > CODE_SPAN) begin : g_width_check
        $error("trit_pair_encoder: 2**DATA_W exceeds 3**NUM_TRITS");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        q_q, q_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2*NUM_TRITS-1:0]   m_data_q, m_data_d;
    logic                     s_ready_q, s_ready_d;
    logic                     m_valid_q, m_valid_d;
    logic                     busy_q, busy_d;

    logic [DATA_W-1:0]        q_div;
    logic [DATA_W-1:0]        q_rem;
    logic [1:0]               trit_code;
    logic [2*NUM_TRITS-1:0]   conv_data;

    // Constant divide by 3 of the running quotient and its remainder digit.
    always_comb begin
        q_div     = q_q / THREE;
        q_rem     = q_q % THREE;
        trit_code = 2'b00;
        if (q_rem == DATA_W'(1)) begin
            trit_code = 2'b01;
        end else if (q_rem == DATA_W'(2)) begin
            trit_code = 2'b10;
        end
    end

    // Only the digit slot selected by cnt takes the new code; the others hold.
    for (genvar gi = 0; gi < NUM_TRITS; gi++) begin : g_slot
        assign conv_data[2*gi +: 2] = (cnt_q == CNT_W'(gi)) ? trit_code
                                                              : m_data_q[2*gi +: 2];
    end

    // Next-state logic; handshake outputs are decoded from the next state so
    // they come straight out of flops and never see m_ready combinationally.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        m_data_d = m_data_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    q_d      = s_data;
                    cnt_d    = '0;
                    m_data_d = '0;
                    state_d  = ST_CONV;
                end
            end
            ST_CONV: begin
                m_data_d = conv_data;
                q_d      = q_div;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        s_ready_d = (state_d == ST_IDLE);
        m_valid_d = (state_d == ST_OUT);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            q_q       <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
        end
    end

    // A quotient left over after the last digit means the input did not fit.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == ST_CONV && cnt_q == LAST_CNT) begin
            assert (q_div == '0);
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = busy_q;

endmodule
